// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT input frame collector.
package fft_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_GAIN_SHIFT = 8;
   localparam int MAX_POW        = 12;

   // Output sample width: input width plus the gain shift, no rounding or saturation.
   function automatic int out_width(input int dw, input int gs);
      return dw + gs;
   endfunction

   localparam int DEF_OUT_WIDTH = out_width(DEF_DATA_WIDTH, DEF_GAIN_SHIFT);

   // Complex sample at the default input width.
   typedef struct packed {
      logic signed [DEF_DATA_WIDTH-1:0] re;
      logic signed [DEF_DATA_WIDTH-1:0] im;
   } cplx_t;

   // Reverse the low 'pow' bits of v; upper bits are returned as zero.
   function automatic logic [MAX_POW-1:0] bitrev(input logic [MAX_POW-1:0] v, input int pow);
      logic [MAX_POW-1:0] r;
      r = {MAX_POW{1'b0}};
      for (int b = 0; b < MAX_POW; b++) begin
         if (b < pow) begin
            r[pow-1-b] = v[b];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_frame_collector_if.sv
// Sink (serial sample) and source (parallel frame) signals of the collector.
interface fft_frame_collector_if #(
   parameter int DATA_WIDTH = 16,
   parameter int POW        = 3,
   parameter int GAIN_SHIFT = 8
);
   import fft_pkg::*;

   localparam int N         = 1 << POW;
   localparam int OUT_WIDTH = out_width(DATA_WIDTH, GAIN_SHIFT);

   logic                         sink_valid;
   logic                         sink_ready;
   logic                         sink_sop;
   logic signed [DATA_WIDTH-1:0] sink_r;
   logic signed [DATA_WIDTH-1:0] sink_i;
   logic                         source_valid;
   logic                         source_ready;
   logic signed [OUT_WIDTH-1:0]  source_r [N];
   logic signed [OUT_WIDTH-1:0]  source_i [N];
   logic                         frame_err;

   // Sample producer / frame consumer side.
   modport master (
      output sink_valid, sink_sop, sink_r, sink_i, source_ready,
      input  sink_ready, source_valid, source_r, source_i, frame_err
   );

   // Collector side.
   modport slave (
      input  sink_valid, sink_sop, sink_r, sink_i, source_ready,
      output sink_ready, source_valid, source_r, source_i, frame_err
   );

endinterface

// File: rtl/fft_frame_collector.sv
// Serial-to-parallel frame collector: fills a frame buffer one sample per
// cycle and hands complete frames to a parallel output register, with a
// one-frame holding stage so back-to-back frames stream without bubbles.
module fft_frame_collector
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int POW        = 3,
   parameter int GAIN_SHIFT = 8,
   parameter int BIT_REV    = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   fft_frame_collector_if.slave  bus
);

   localparam int N         = 1 << POW;
   localparam int OUT_WIDTH = out_width(DATA_WIDTH, GAIN_SHIFT);
   localparam logic [POW:0] LAST_IDX = (POW+1)'(N - 1);

   typedef struct packed {
      logic signed [DATA_WIDTH-1:0] re;
      logic signed [DATA_WIDTH-1:0] im;
   } sample_t;

   logic [POW:0]                cnt_q, cnt_d;
   logic                        full_q, full_d;
   logic                        err_q, err_d;
   logic                        valid_q, valid_d;
   sample_t                     fill_q [N];
   sample_t                     fill_d [N];
   logic signed [OUT_WIDTH-1:0] out_r_q [N];
   logic signed [OUT_WIDTH-1:0] out_r_d [N];
   logic signed [OUT_WIDTH-1:0] out_i_q [N];
   logic signed [OUT_WIDTH-1:0] out_i_d [N];

   logic accept_s;
   logic out_free_s;
   logic load_s;

   assign accept_s   = bus.sink_valid && !full_q;
   assign out_free_s = !valid_q || bus.source_ready;

   // Next-state: fill buffer writes, frame completion, output transfer.
   always_comb begin
      logic [MAX_POW-1:0]          k;
      logic signed [OUT_WIDTH-1:0] ext_r;
      logic signed [OUT_WIDTH-1:0] ext_i;
      cnt_d   = cnt_q;
      full_d  = full_q;
      err_d   = 1'b0;
      valid_d = valid_q && !bus.source_ready;
      fill_d  = fill_q;
      out_r_d = out_r_q;
      out_i_d = out_i_q;
      load_s  = 1'b0;
      k       = {MAX_POW{1'b0}};
      ext_r   = {OUT_WIDTH{1'b0}};
      ext_i   = {OUT_WIDTH{1'b0}};

      if (accept_s) begin
         if (bus.sink_sop) begin
            // Realign: a sop mid-frame drops the partial frame.
            fill_d[0] = '{re: bus.sink_r, im: bus.sink_i};
            cnt_d     = (POW+1)'(1);
            err_d     = (cnt_q != {(POW+1){1'b0}});
         end else begin
            for (int i = 0; i < N; i++) begin
               if (cnt_q[POW-1:0] == POW'(i)) begin
                  fill_d[i] = '{re: bus.sink_r, im: bus.sink_i};
               end
            end
            if (cnt_q == LAST_IDX) begin
               if (out_free_s) begin
                  load_s = 1'b1;
                  cnt_d  = {(POW+1){1'b0}};
               end else begin
                  full_d = 1'b1;
                  cnt_d  = cnt_q + (POW+1)'(1);
               end
            end else begin
               cnt_d = cnt_q + (POW+1)'(1);
            end
         end
      end else if (full_q && valid_q && bus.source_ready) begin
         load_s = 1'b1;
         full_d = 1'b0;
         cnt_d  = {(POW+1){1'b0}};
      end else begin
         cnt_d = cnt_q;
      end

      if (load_s) begin
         valid_d = 1'b1;
         for (int j = 0; j < N; j++) begin
            if (BIT_REV != 0) begin
               k = bitrev(MAX_POW'(j), POW);
            end else begin
               k = MAX_POW'(j);
            end
            ext_r      = OUT_WIDTH'(fill_d[k[POW-1:0]].re);
            ext_i      = OUT_WIDTH'(fill_d[k[POW-1:0]].im);
            out_r_d[j] = ext_r <<< GAIN_SHIFT;
            out_i_d[j] = ext_i <<< GAIN_SHIFT;
         end
      end else begin
         valid_d = valid_d;
      end
   end

   // State registers; reset drops any partial or pending frame silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= {(POW+1){1'b0}};
         full_q  <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         for (int i = 0; i < N; i++) begin
            fill_q[i]  <= '{re: {DATA_WIDTH{1'b0}}, im: {DATA_WIDTH{1'b0}}};
            out_r_q[i] <= {OUT_WIDTH{1'b0}};
            out_i_q[i] <= {OUT_WIDTH{1'b0}};
         end
      end else begin
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         for (int i = 0; i < N; i++) begin
            fill_q[i]  <= fill_d[i];
            out_r_q[i] <= out_r_d[i];
            out_i_q[i] <= out_i_d[i];
         end
      end
   end

   assign bus.sink_ready   = !full_q;
   assign bus.source_valid = valid_q;
   assign bus.frame_err    = err_q;

   for (genvar g = 0; g < N; g++) begin : g_out
      assign bus.source_r[g] = out_r_q[g];
      assign bus.source_i[g] = out_i_q[g];
   end

endmodule

// File: tb/tb_fft_frame_collector.sv
// Directed bench for fft_frame_collector: natural and bit-reversed instances
// share one stimulus stream; expected values are hand-computed constants.
module tb_fft_frame_collector;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   fft_frame_collector_if #(.DATA_WIDTH(16), .POW(3), .GAIN_SHIFT(8)) b1 ();
   fft_frame_collector_if #(.DATA_WIDTH(16), .POW(3), .GAIN_SHIFT(8)) b2 ();

   fft_frame_collector #(.DATA_WIDTH(16), .POW(3), .GAIN_SHIFT(8), .BIT_REV(0)) u_nat (
      .clk (clk), .rst (rst), .bus (b1.slave)
   );
   fft_frame_collector #(.DATA_WIDTH(16), .POW(3), .GAIN_SHIFT(8), .BIT_REV(1)) u_rev (
      .clk (clk), .rst (rst), .bus (b2.slave)
   );

   assign b2.sink_valid   = b1.sink_valid;
   assign b2.sink_sop     = b1.sink_sop;
   assign b2.sink_r       = b1.sink_r;
   assign b2.sink_i       = b1.sink_i;
   assign b2.source_ready = b1.source_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One sample offered for one cycle; returns at the following negedge.
   task automatic send(input bit sop, input int r, input int i);
      b1.sink_valid = 1'b1;
      b1.sink_sop   = sop;
      b1.sink_r     = 16'(r);
      b1.sink_i     = 16'(i);
      @(posedge clk);
      @(negedge clk);
      b1.sink_valid = 1'b0;
      b1.sink_sop   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      bit ready_dropped;
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      b1.sink_valid   = 1'b0;
      b1.sink_sop     = 1'b0;
      b1.sink_r       = 16'sd0;
      b1.sink_i       = 16'sd0;
      b1.source_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);

      // Reset state
      chk("rst_valid", b1.source_valid, 0);
      chk("rst_ready", b1.sink_ready, 1);
      chk("rst_err", b1.frame_err, 0);
      chk("rst_r0", b1.source_r[0], 0);
      rst = 1'b0;
      @(negedge clk);

      // Natural order with random sink_valid gaps
      for (int s = 1; s <= 8; s++) begin
         send(s == 1, s, -s);
         if (s == 1) chk("sop_at_zero_no_err", b1.frame_err, 0);
         if (s == 7) chk("valid_before_last", b1.source_valid, 0);
         if (s < 8) idle($urandom_range(0, 2));
      end
      chk("nat_valid", b1.source_valid, 1);
      chk("nat_r0", b1.source_r[0], 256);
      chk("nat_r7", b1.source_r[7], 2048);
      chk("nat_i0", b1.source_i[0], -256);
      chk("nat_i7", b1.source_i[7], -2048);

      // Back-to-back frame: sink_ready must never drop
      ready_dropped = 1'b0;
      for (int s = 9; s <= 16; s++) begin
         send(s == 9, s, 0);
         if (!b1.sink_ready) ready_dropped = 1'b1;
      end
      chk("b2b_ready_held", ready_dropped, 0);
      chk("b2b_valid", b1.source_valid, 1);
      chk("b2b_r0", b1.source_r[0], 9 * 256);
      chk("b2b_r7", b1.source_r[7], 16 * 256);
      idle(1);
      chk("valid_drops_after_hs", b1.source_valid, 0);

      // Backpressure: two frames with source_ready low
      b1.source_ready = 1'b0;
      for (int s = 1; s <= 16; s++) begin
         send(s == 1 || s == 9, (s <= 8) ? s : s + 2, 0);
         if (s == 15) chk("bp_ready_before_16", b1.sink_ready, 1);
      end
      chk("bp_ready_low", b1.sink_ready, 0);
      chk("bp_hold_r0", b1.source_r[0], 256);
      idle(1);
      chk("bp_still_low", b1.sink_ready, 0);
      chk("bp_still_valid", b1.source_valid, 1);
      chk("bp_still_r7", b1.source_r[7], 8 * 256);
      b1.source_ready = 1'b1;
      idle(1);
      b1.source_ready = 1'b0;
      chk("bp_f2_valid", b1.source_valid, 1);
      chk("bp_f2_r0", b1.source_r[0], 11 * 256);
      chk("bp_f2_ready", b1.sink_ready, 1);
      b1.source_ready = 1'b1;
      idle(1);
      chk("bp_drain", b1.source_valid, 0);

      // Misalignment: 5 samples then a new sop
      for (int s = 1; s <= 5; s++) send(s == 1, s, 0);
      chk("mis_no_err_yet", b1.frame_err, 0);
      send(1'b1, 100, 0);
      chk("mis_err_pulse", b1.frame_err, 1);
      idle(1);
      chk("mis_err_one_cycle", b1.frame_err, 0);
      for (int s = 1; s <= 7; s++) send(1'b0, 100 + s, 0);
      chk("mis_valid", b1.source_valid, 1);
      chk("mis_r0", b1.source_r[0], 100 * 256);
      chk("mis_r1", b1.source_r[1], 101 * 256);
      idle(1);

      // Bit reversal: inputs 0..7; hold output with source_ready low
      b1.source_ready = 1'b0;
      for (int s = 0; s <= 7; s++) send(s == 0, s, 0);
      chk("rev_valid", b2.source_valid, 1);
      chk("rev_r1", b2.source_r[1], 4 * 256);
      chk("rev_r3", b2.source_r[3], 6 * 256);
      chk("rev_r6", b2.source_r[6], 3 * 256);
      chk("rev_nat_r1", b1.source_r[1], 256);

      // Reset mid-frame while an output frame is held
      for (int s = 0; s < 4; s++) send(s == 0, 50 + s, 0);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", b1.source_valid, 0);
      chk("mid_rst_r1", b1.source_r[1], 0);
      chk("mid_rst_ready", b1.sink_ready, 1);
      chk("mid_rst_err", b1.frame_err, 0);
      @(negedge clk);
      rst = 1'b0;
      b1.source_ready = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 8; s++) begin
         send(s == 0, 200 + s, 0);
         if (s == 0) chk("post_rst_no_err", b1.frame_err, 0);
      end
      chk("post_rst_valid", b1.source_valid, 1);
      chk("post_rst_r0", b1.source_r[0], 200 * 256);
      chk("post_rst_r7", b1.source_r[7], 207 * 256);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
